// File: rtl/mt_fetch_pc.sv
`default_nettype none
// ============================================================================
// mt_fetch_pc : per-thread PCs, round-robin thread pick, one-entry fetch reg
// Rev 1.0
// ============================================================================
module mt_fetch_pc #(
  parameter int unsigned NTHREADS = 4,
  parameter int unsigned TID_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NTHREADS-1:0] thread_en,
  output logic                fetch_valid,
  input  logic                fetch_ready,
  output logic [31:0]         fetch_pc,
  output logic [TID_W-1:0]    fetch_tid,
  input  logic                br_valid,
  input  logic [TID_W-1:0]    br_tid,
  input  logic                br_taken,
  input  logic [31:0]         br_target,
  output logic [NTHREADS-1:0] flush
);

  logic [31:0]         pc_q [NTHREADS];
  logic [31:0]         pc_d [NTHREADS];
  logic [TID_W-1:0]    rr_q;
  logic                fv_q;
  logic [31:0]         fpc_q;
  logic [TID_W-1:0]    ftid_q;
  logic [NTHREADS-1:0] flush_q;
  logic [NTHREADS-1:0] flush_d;

  logic                redir;
  logic                acc;
  logic                kill;
  logic                load;
  logic [31:0]         tgt;
  logic                sel_found;
  logic [TID_W-1:0]    sel_tid;
  logic [TID_W-1:0]    cand;

  assign redir = br_valid & br_taken;
  assign tgt   = {br_target[31:2], 2'b00};
  assign acc   = fv_q & fetch_ready;
  // A redirect of the held thread lets the register reload even under backpressure.
  assign kill  = redir & fv_q & (ftid_q == br_tid);
  assign load  = ~fv_q | fetch_ready | kill;

  always_comb begin
    for (int t = 0; t < NTHREADS; t++) begin
      pc_d[t]    = pc_q[t];
      flush_d[t] = redir && (br_tid == TID_W'(t));
      if (redir && (br_tid == TID_W'(t))) begin
        pc_d[t] = tgt;
      end else if (acc && (ftid_q == TID_W'(t))) begin
        pc_d[t] = pc_q[t] + 32'd4;
      end
    end
  end

  // Candidate index wraps naturally because NTHREADS is a power of two.
  always_comb begin
    sel_found = 1'b0;
    sel_tid   = rr_q;
    cand      = rr_q;
    for (int i = 0; i < NTHREADS; i++) begin
      cand = rr_q + TID_W'(i);
      if (!sel_found && thread_en[cand]) begin
        sel_found = 1'b1;
        sel_tid   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NTHREADS; t++) begin
        pc_q[t] <= RESET_PC;
      end
      rr_q    <= '0;
      fv_q    <= 1'b0;
      fpc_q   <= '0;
      ftid_q  <= '0;
      flush_q <= '0;
    end else begin
      for (int t = 0; t < NTHREADS; t++) begin
        pc_q[t] <= pc_d[t];
      end
      flush_q <= flush_d;
      if (load) begin
        fv_q <= sel_found;
        if (sel_found) begin
          ftid_q <= sel_tid;
          fpc_q  <= pc_d[sel_tid];
          rr_q   <= sel_tid + TID_W'(1);
        end
      end
    end
  end

  assign fetch_valid = fv_q;
  assign fetch_pc    = fpc_q;
  assign fetch_tid   = ftid_q;
  assign flush       = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_mt_fetch_pc.sv
`default_nettype none
// ============================================================================
// tb_mt_fetch_pc : directed + random stimulus against a behavioural model
// Rev 1.0
// ============================================================================
module tb_mt_fetch_pc;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] thread_en;
  logic         fetch_valid;
  logic         fetch_ready;
  logic [31:0]  fetch_pc;
  logic [1:0]   fetch_tid;
  logic         br_valid;
  logic [1:0]   br_tid;
  logic         br_taken;
  logic [31:0]  br_target;
  logic [N-1:0] flush;

  int checks = 0;
  int errors = 0;

  mt_fetch_pc #(.NTHREADS(N), .TID_W(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .thread_en(thread_en),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_tid(fetch_tid),
    .br_valid(br_valid), .br_tid(br_tid), .br_taken(br_taken),
    .br_target(br_target), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer thread numbers and modulo arithmetic.
  logic [31:0] m_pc  [N];
  logic [31:0] m_npc [N];
  int          m_rr, m_tid;
  bit          m_fv;
  logic [31:0] m_fpc;
  logic [N-1:0] m_flush;

  initial begin
    bit redir, acc, kill, found;
    int pick, t;
    logic [31:0] tgt;
    for (int i = 0; i < N; i++) m_pc[i] = 32'h0;
    m_rr = 0; m_tid = 0; m_fv = 0; m_fpc = 0; m_flush = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < N; i++) m_pc[i] = 32'h0;
        m_rr = 0; m_tid = 0; m_fv = 0; m_fpc = 0; m_flush = 0;
      end else begin
        redir = br_valid && br_taken;
        tgt   = br_target & 32'hFFFF_FFFC;
        acc   = m_fv && fetch_ready;
        for (int i = 0; i < N; i++) begin
          if (redir && i == int'(br_tid))  m_npc[i] = tgt;
          else if (acc && i == m_tid)      m_npc[i] = m_pc[i] + 32'd4;
          else                             m_npc[i] = m_pc[i];
        end
        kill = redir && m_fv && (m_tid == int'(br_tid));
        if (!m_fv || fetch_ready || kill) begin
          found = 0; pick = 0;
          for (int k = 0; k < N; k++) begin
            t = (m_rr + k) % N;
            if (!found && thread_en[t]) begin found = 1; pick = t; end
          end
          m_fv = found;
          if (found) begin
            m_tid = pick;
            m_fpc = m_npc[pick];
            m_rr  = (pick + 1) % N;
          end
        end
        m_flush = redir ? (4'b0001 << br_tid) : 4'b0000;
        for (int i = 0; i < N; i++) m_pc[i] = m_npc[i];
      end
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_valid", 32'(fetch_valid), 32'(m_fv));
      chk("m_flush", 32'(flush), 32'(m_flush));
      if (m_fv) begin
        chk("m_pc", fetch_pc, m_fpc);
        chk("m_tid", 32'(fetch_tid), 32'(m_tid));
      end
    end
  end

  task automatic expect_req(input string nm, input int tid, input logic [31:0] pc,
                            input logic [3:0] fl);
    @(negedge clk);
    chk({nm, "_v"}, 32'(fetch_valid), 32'd1);
    chk({nm, "_tid"}, 32'(fetch_tid), 32'(tid));
    chk({nm, "_pc"}, fetch_pc, pc);
    chk({nm, "_fl"}, 32'(flush), 32'(fl));
  endtask

  task automatic set_br(input bit v, input bit tk, input int tid, input logic [31:0] tg);
    br_valid  = v;
    br_taken  = tk;
    br_tid    = 2'(tid);
    br_target = tg;
  endtask

  initial begin
    rst_n = 1'b0; thread_en = 4'b1111; fetch_ready = 1'b1;
    set_br(0, 0, 0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_v", 32'(fetch_valid), 32'd0);
    chk("rst_pc", fetch_pc, 32'd0);
    chk("rst_tid", 32'(fetch_tid), 32'd0);
    chk("rst_fl", 32'(flush), 32'd0);
    rst_n = 1'b1;

    expect_req("rr0", 0, 32'h0, 4'b0);
    expect_req("rr1", 1, 32'h0, 4'b0);
    expect_req("rr2", 2, 32'h0, 4'b0);
    expect_req("rr3", 3, 32'h0, 4'b0);
    expect_req("rr4", 0, 32'h4, 4'b0);
    expect_req("rr5", 1, 32'h4, 4'b0);
    expect_req("rr6", 2, 32'h4, 4'b0);

    fetch_ready = 1'b0;
    repeat (5) expect_req("hold", 2, 32'h4, 4'b0);
    fetch_ready = 1'b1;
    expect_req("resume", 3, 32'h4, 4'b0);

    set_br(1, 1, 2, 32'h103);
    expect_req("brnh", 0, 32'h8, 4'b0100);
    set_br(0, 0, 0, 32'h0);
    expect_req("brnh1", 1, 32'h8, 4'b0);
    expect_req("brtgt", 2, 32'h100, 4'b0);
    expect_req("brnh3", 3, 32'h8, 4'b0);
    expect_req("brnh4", 0, 32'hc, 4'b0);
    expect_req("brnh5", 1, 32'hc, 4'b0);
    expect_req("brtgt4", 2, 32'h104, 4'b0);

    set_br(1, 0, 2, 32'h103);
    expect_req("ntk", 3, 32'hc, 4'b0);
    set_br(0, 0, 0, 32'h0);
    expect_req("ntk1", 0, 32'h10, 4'b0);
    expect_req("ntk2", 1, 32'h10, 4'b0);
    expect_req("ntk3", 2, 32'h108, 4'b0);
    expect_req("pre0", 3, 32'h10, 4'b0);
    expect_req("pre1", 0, 32'h14, 4'b0);
    expect_req("pre2", 1, 32'h14, 4'b0);

    fetch_ready = 1'b0;
    set_br(1, 1, 1, 32'h200);
    expect_req("kill", 2, 32'h10c, 4'b0010);
    fetch_ready = 1'b1;
    set_br(0, 0, 0, 32'h0);
    expect_req("kill1", 3, 32'h14, 4'b0);
    expect_req("kill2", 0, 32'h18, 4'b0);
    expect_req("killt", 1, 32'h200, 4'b0);
    expect_req("ar0", 2, 32'h110, 4'b0);
    expect_req("ar1", 3, 32'h18, 4'b0);
    expect_req("ar2", 0, 32'h1c, 4'b0);

    set_br(1, 1, 0, 32'h40);
    expect_req("accr", 1, 32'h204, 4'b0001);
    set_br(0, 0, 0, 32'h0);
    expect_req("accr1", 2, 32'h114, 4'b0);
    expect_req("accr2", 3, 32'h1c, 4'b0);
    expect_req("accrt", 0, 32'h40, 4'b0);

    thread_en = 4'b0001;
    expect_req("one0", 0, 32'h44, 4'b0);
    expect_req("one1", 0, 32'h48, 4'b0);
    expect_req("one2", 0, 32'h4c, 4'b0);
    set_br(1, 1, 0, 32'hFFFF_FFFE);
    expect_req("wrapt", 0, 32'hFFFF_FFFC, 4'b0001);
    set_br(0, 0, 0, 32'h0);
    expect_req("wrap0", 0, 32'h0, 4'b0);
    expect_req("wrap1", 0, 32'h4, 4'b0);

    thread_en = 4'b0000;
    @(negedge clk);
    chk("dis_v0", 32'(fetch_valid), 32'd0);
    @(negedge clk);
    chk("dis_v1", 32'(fetch_valid), 32'd0);

    thread_en = 4'b1111;
    set_br(1, 1, 3, 32'h300);
    @(negedge clk);
    chk("pre_rst_fl", 32'(flush), 32'b1000);
    chk("pre_rst_v", 32'(fetch_valid), 32'd1);
    set_br(0, 0, 0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_v", 32'(fetch_valid), 32'd0);
    chk("arst_pc", fetch_pc, 32'd0);
    chk("arst_tid", 32'(fetch_tid), 32'd0);
    chk("arst_fl", 32'(flush), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3000) begin
      @(negedge clk);
      thread_en   = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      fetch_ready = ($urandom_range(0, 3) != 0);
      set_br($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
